// File: rtl/eight_bit_search_controller.sv
// eight_bit_search_controller
//   Binary-search engine that drives an external 8-bit magnitude comparator.
//   Each step it presents a guess and consumes a lesser/equal/greater verdict.
//   It converges on the hidden target in at most 9 verdicts.
//   It reports the found value, the step count, and a not-found, error or
//   timeout status.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   start              begin a search (sampled only in IDLE)
//   guess/guess_valid  probe value presented to the comparator
//   result_valid       verdict bits are valid this cycle
//   lesser/equal/greater  comparator verdict (guess vs target)
//   busy               search in progress (PROBE or DONE)
//   done               one-cycle pulse when a search terminates
//   found/error/result/steps  outcome of the last search, held until next start
module eight_bit_search_controller #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  output logic [7:0] guess,
  output logic       guess_valid,
  input  logic       result_valid,
  input  logic       lesser,
  input  logic       equal,
  input  logic       greater,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic       error,
  output logic [7:0] result,
  output logic [3:0] steps
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

  state_t        state, state_n;
  logic [7:0]    lo, hi, lo_n, hi_n, guess_n;
  logic [8:0]    sum;
  logic [CW-1:0] wait_cnt;
  logic          accept, term, hit, bad, tmo;

  assign guess_valid = (state == PROBE);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign accept      = guess_valid & result_valid;

  // Verdict evaluation: narrowed bounds and whether this accept ends the search.
  // Bounds never wrap; the guess==0/255 cases terminate before any update.
  always_comb begin
    lo_n = lo;
    hi_n = hi;
    term = 1'b0;
    hit  = 1'b0;
    bad  = 1'b0;
    if (accept) begin
      if (!$onehot({lesser, equal, greater})) begin
        bad  = 1'b1;
        term = 1'b1;
      end else if (equal) begin
        hit  = 1'b1;
        term = 1'b1;
      end else if (lesser) begin
        if (guess == 8'hFF) term = 1'b1;
        else begin
          lo_n = guess + 8'd1;
          if (lo_n > hi) term = 1'b1;
        end
      end else begin
        if (guess == 8'h00) term = 1'b1;
        else begin
          hi_n = guess - 8'd1;
          if (lo > hi_n) term = 1'b1;
        end
      end
    end
  end

  // The sum needs 9 bits so that lo+hi never overflows before the halving.
  assign sum     = {1'b0, lo_n} + {1'b0, hi_n};
  assign guess_n = sum[8:1];

  // An accept on the same edge as the timeout takes priority.
  assign tmo = guess_valid & ~accept & (wait_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = PROBE;
      PROBE:   if (term || tmo) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      lo       <= 8'd0;
      hi       <= 8'd255;
      guess    <= 8'd0;
      wait_cnt <= '0;
      steps    <= 4'd0;
      found    <= 1'b0;
      error    <= 1'b0;
      result   <= 8'd0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          lo       <= 8'd0;
          hi       <= 8'd255;
          guess    <= 8'd127;
          wait_cnt <= '0;
          steps    <= 4'd0;
          found    <= 1'b0;
          error    <= 1'b0;
        end
        PROBE: begin
          if (accept) begin
            steps    <= steps + 4'd1;
            wait_cnt <= '0;
            lo       <= lo_n;
            hi       <= hi_n;
            if (term) begin
              result <= guess;
              found  <= hit;
              error  <= bad;
            end else begin
              guess <= guess_n;
            end
          end else if (tmo) begin
            result <= guess;
            found  <= 1'b0;
            error  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eight_bit_search_controller.sv
// Directed bench for eight_bit_search_controller (TIMEOUT=4).
// A behavioural comparator answers the DUT's guesses. Its modes are:
// consistent with a target, always-greater, illegal lesser+greater, and silent.
module tb_eight_bit_search_controller;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] guess;
  logic       guess_valid;
  logic       result_valid;
  logic       lesser, equal, greater;
  logic       busy, done, found, error;
  logic [7:0] result;
  logic [3:0] steps;

  logic [7:0] target = 8'd0;
  int         mode = 0;  // 0 consistent, 1 always greater, 2 lesser+greater, 3 silent

  int n_tests = 0;
  int n_fail  = 0;

  // Per-search observations, filled by do_search
  int gq[$];
  int first_gv, last_acc, done_cyc;
  bit timed_out;

  always #5 clk = ~clk;

  // result_valid stays high outside PROBE so the DUT must ignore it there
  assign result_valid = (mode != 3);
  assign lesser  = (mode == 0) ? (guess < target) : (mode == 2);
  assign equal   = (mode == 0) && (guess == target);
  assign greater = (mode == 0) ? (guess > target) : (mode == 1 || mode == 2);

  eight_bit_search_controller #(.TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .guess(guess), .guess_valid(guess_valid), .result_valid(result_valid),
    .lesser(lesser), .equal(equal), .greater(greater),
    .busy(busy), .done(done), .found(found), .error(error),
    .result(result), .steps(steps)
  );

  // Pulse start, then follow the search on negedges until done or the budget expires
  task automatic do_search(input logic [7:0] tgt, input int md, input bit mid_start);
    int cyc;
    target = tgt;
    mode = md;
    gq.delete();
    first_gv = -1;
    last_acc = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!done && cyc < 60) begin
      if (guess_valid && first_gv < 0) first_gv = cyc;
      if (guess_valid && result_valid) begin
        gq.push_back(int'(guess));
        last_acc = cyc;
      end
      start = mid_start && (cyc == 2 || cyc == 3);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    done_cyc = cyc;
    timed_out = !done;
    n_tests++;
    if (timed_out) begin
      n_fail++;
      $display("FAIL search_timeout: done not seen within %0d cycles", cyc);
    end
  endtask

  task automatic check_seq(input string name, input int exp[$]);
    bit ok;
    ok = (gq.size() == exp.size());
    if (ok) foreach (exp[i]) if (gq[i] != exp[i]) ok = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %p expected %p", name, gq, exp);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #12;
    n_tests++;
    if ({guess, guess_valid, busy, done, found, error, result, steps} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got g=%0d gv=%b b=%b d=%b f=%b e=%b r=%0d s=%0d expected all 0",
               guess, guess_valid, busy, done, found, error, result, steps);
    end
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_target100();
    do_search(8'd100, 0, 1'b0);
    check_seq("t100_guesses", '{127, 63, 95, 111, 103, 99, 101, 100});
    n_tests++;
    if (done_cyc - last_acc !== 1) begin
      n_fail++;
      $display("FAIL t100_done_latency: got %0d expected 1", done_cyc - last_acc);
    end
    n_tests++;
    if (found !== 1'b1 || result !== 8'd100 || steps !== 4'd8 || error !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL t100_status: got f=%b r=%0d s=%0d e=%b b=%b expected f=1 r=100 s=8 e=0 b=1",
               found, result, steps, error, busy);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t100_done_pulse: got d=%b b=%b expected d=0 b=0", done, busy);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (found !== 1'b1 || result !== 8'd100 || steps !== 4'd8) begin
      n_fail++;
      $display("FAIL t100_hold: got f=%b r=%0d s=%0d expected f=1 r=100 s=8", found, result, steps);
    end
  endtask

  task automatic test_bounds();
    do_search(8'd255, 0, 1'b0);
    check_seq("t255_guesses", '{127, 191, 223, 239, 247, 251, 253, 254, 255});
    n_tests++;
    if (found !== 1'b1 || steps !== 4'd9 || result !== 8'd255) begin
      n_fail++;
      $display("FAIL t255_status: got f=%b s=%0d r=%0d expected f=1 s=9 r=255", found, steps, result);
    end
    @(negedge clk);
    do_search(8'd0, 0, 1'b0);
    check_seq("t0_guesses", '{127, 63, 31, 15, 7, 3, 1, 0});
    n_tests++;
    if (found !== 1'b1 || steps !== 4'd8 || result !== 8'd0) begin
      n_fail++;
      $display("FAIL t0_status: got f=%b s=%0d r=%0d expected f=1 s=8 r=0", found, steps, result);
    end
    @(negedge clk);
  endtask

  task automatic test_always_greater();
    do_search(8'd0, 1, 1'b0);
    check_seq("gt_guesses", '{127, 63, 31, 15, 7, 3, 1, 0});
    n_tests++;
    if (found !== 1'b0 || error !== 1'b0 || result !== 8'd0 || steps !== 4'd8) begin
      n_fail++;
      $display("FAIL gt_status: got f=%b e=%b r=%0d s=%0d expected f=0 e=0 r=0 s=8",
               found, error, result, steps);
    end
    @(negedge clk);
  endtask

  task automatic test_bad_code();
    do_search(8'd50, 2, 1'b0);
    n_tests++;
    if (last_acc !== 0 || done_cyc !== 1) begin
      n_fail++;
      $display("FAIL bad_latency: got acc=%0d done=%0d expected acc=0 done=1", last_acc, done_cyc);
    end
    n_tests++;
    if (error !== 1'b1 || found !== 1'b0 || result !== 8'd127 || steps !== 4'd1) begin
      n_fail++;
      $display("FAIL bad_status: got e=%b f=%b r=%0d s=%0d expected e=1 f=0 r=127 s=1",
               error, found, result, steps);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    do_search(8'd50, 3, 1'b0);
    n_tests++;
    if (done_cyc - first_gv !== 4) begin
      n_fail++;
      $display("FAIL tmo_latency: got %0d expected 4", done_cyc - first_gv);
    end
    n_tests++;
    if (error !== 1'b1 || found !== 1'b0 || result !== 8'd127 || steps !== 4'd0) begin
      n_fail++;
      $display("FAIL tmo_status: got e=%b f=%b r=%0d s=%0d expected e=1 f=0 r=127 s=0",
               error, found, result, steps);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_start();
    do_search(8'd100, 0, 1'b1);
    check_seq("midstart_guesses", '{127, 63, 95, 111, 103, 99, 101, 100});
    n_tests++;
    if (found !== 1'b1 || result !== 8'd100 || steps !== 4'd8) begin
      n_fail++;
      $display("FAIL midstart_status: got f=%b r=%0d s=%0d expected f=1 r=100 s=8", found, result, steps);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int seen_done;
    target = 8'd100;
    mode = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    n_tests++;
    if ({guess, guess_valid, busy, done, found, error, result, steps} !== 29'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got g=%0d gv=%b b=%b d=%b f=%b e=%b r=%0d s=%0d expected all 0",
               guess, guess_valid, busy, done, found, error, result, steps);
    end
    @(negedge clk); rstn = 1'b1;
    seen_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    n_tests++;
    if (seen_done !== 0) begin
      n_fail++;
      $display("FAIL midreset_no_done: got %0d active cycles expected 0", seen_done);
    end
    do_search(8'd100, 0, 1'b0);
    n_tests++;
    if (gq.size() == 0 || gq[0] !== 127 || found !== 1'b1 || steps !== 4'd8) begin
      n_fail++;
      $display("FAIL midreset_restart: got first=%0d f=%b s=%0d expected first=127 f=1 s=8",
               (gq.size() == 0) ? -1 : gq[0], found, steps);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_target100();
    test_bounds();
    test_always_greater();
    test_bad_code();
    test_timeout();
    test_mid_start();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/eight_bit_search_controller.md
Name: eight_bit_search_controller

Overview:
- Binary-search engine that sits on the other side of the team's 8-bit magnitude comparator.
- Drives a guess into an external comparator each step and consumes the comparator's lesser/equal/greater verdict.
- Converges on the hidden 8-bit target in at most 9 comparisons.
- Reports the found value, step count, and not-found, protocol-error or timeout status.

Parameters:
TIMEOUT, 64, max cycles to wait for result_valid per guess (>=1); counter width = clog2(TIMEOUT+1)

Ports:
clk  input  1  rising-edge clock
rstn  input  1  reset, asynchronous, active-low
start  input  1  begin a search; sampled only in IDLE
guess  output  8  current probe value presented to the comparator as x
guess_valid  output  1  guess is stable and awaiting a verdict
result_valid  input  1  lesser/equal/greater are valid this cycle
lesser  input  1  guess < target
equal  input  1  guess == target
greater  input  1  guess > target
busy  output  1  search in progress (state != IDLE)
done  output  1  one-cycle pulse when a search terminates
found  output  1  last search ended on equal
error  output  1  last search ended on a bad verdict code or timeout
result  output  8  final guess of the last search
steps  output  4  verdicts consumed in the last or current search (0..9)

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, lo=0, hi=255, guess=0, all outputs 0.
- States: IDLE, PROBE, DONE.
- IDLE, start=1:
  - load lo=0, hi=255; clear steps, found, error; clear wait counter.
  - go to PROBE.
  - the next cycle presents guess=127 with guess_valid=1.
- PROBE:
  - guess = (lo+hi)>>1, with the sum computed 9 bits wide; guess is registered.
  - guess_valid=1 throughout PROBE.
  - A verdict is accepted on a rising edge where guess_valid and result_valid are both 1; steps increments on that edge.
- Verdict handling on the accepting edge:
  - equal: result=guess, found=1 → DONE.
  - lesser:
    - if guess==255: result=guess, found=0 → DONE.
    - else lo=guess+1; if lo>hi → DONE, not found.
    - otherwise stay in PROBE; the new guess is valid the next cycle (back-to-back accepts allowed, one verdict per cycle max).
  - greater:
    - if guess==0: result=0, found=0 → DONE.
    - else hi=guess-1; if lo>hi → DONE, not found.
  - Never wrap lo or hi.
  - Verdict not exactly one-hot (000, or two or more bits set): error=1, found=0, result=guess → DONE.
- Timeout:
  - Wait counter increments each PROBE cycle without an accept; it is cleared on each accept.
  - On reaching TIMEOUT: error=1, found=0, result=guess → DONE.
  - An accept on the same edge as timeout wins.
- DONE: lasts exactly 1 cycle with done=1 and guess_valid=0, then IDLE.
- result, found, error and steps hold their values until the next accepted start.
- result_valid is ignored when guess_valid=0.
- start is ignored unless in IDLE, including start held high through a search.
- With a consistent comparator, a search finishes within 9 accepts: steps<=9, found=1.
- rstn asserted mid-search aborts immediately to reset values; no done pulse.
- busy=1 in PROBE and DONE.

Test Plan:
- Consistent comparator, target=100, result_valid same cycle as guess_valid:
  - guesses 127,63,95,111,103,99,101,100.
  - done one cycle after the 8th accept; found=1, result=100, steps=8, error=0.
- Target=255:
  - guesses 127,191,223,239,247,251,253,254,255.
  - found=1, steps=9.
- Target=0:
  - guesses 127,63,31,15,7,3,1,0.
  - found=1, steps=8.
- Responder always returns greater:
  - guess sequence ends at 0.
  - done with found=0, error=0, result=0, steps=8.
- Verdict code lesser=1, greater=1 on the first accept:
  - done next cycle; error=1, found=0, result=127, steps=1.
- TIMEOUT=4, result_valid never asserted:
  - done 4 cycles after guess_valid rises; error=1, result=127, steps=0.
- start pulsed mid-search:
  - ignored; sequence unchanged.
- rstn pulsed low mid-search:
  - all outputs 0 immediately, no done pulse.
  - next start restarts at guess=127.
